// File: rtl/bz_sound_pkg.sv
// rtl/bz_sound_pkg.sv - shared types and envelope peaks for the shell/explosion sound block
package bz_sound_pkg;

    typedef logic [7:0]         env_t;
    typedef logic signed [15:0] audio_t;

    localparam env_t SHELL_PEAK      = 8'hC0;
    localparam env_t EXPLO_PEAK_LOUD = 8'hFF;
    localparam env_t EXPLO_PEAK_SOFT = 8'h80;

endpackage

// File: rtl/env_decay.sv
// rtl/env_decay.sv - 8-bit decaying envelope with sample-rate prescaler
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   sample_en   audio sample strobe; advances the prescaler
//   enable      0 clears envelope and prescaler on the next clk
//   start       load peak and restart the prescaler (wins over a decay step)
//   peak        value loaded on start
//   env         current envelope
module env_decay
    import bz_sound_pkg::*;
#(
    parameter int DIV         = 48,
    parameter int DECAY_SHIFT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic enable,
    input  logic start,
    input  env_t peak,
    output env_t env
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    env_t          dec;

    // Fractional decay, but never less than 1 so the tail actually reaches 0.
    always_comb begin
        dec = env >> DECAY_SHIFT;
        if (dec == '0) begin
            dec = 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env <= '0;
            cnt <= '0;
        end else if (!enable) begin
            env <= '0;
            cnt <= '0;
        end else if (start) begin
            env <= peak;
            cnt <= '0;
        end else if (sample_en && env != '0) begin
            // cnt is left at 0 by the wrap that takes env to 0, so it freezes there.
            if (cnt == LAST) begin
                cnt <= '0;
                env <= env - dec;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shell_explo_sound.sv
// rtl/shell_explo_sound.sv - shell and explosion noise channels, filter and mixer
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_en     one-cycle audio sample strobe
//   sound_enable  0 silences and clears the block
//   shell_noise   shell noise bit
//   explo_noise   explosion noise bit
//   shell_trig    rising edge starts a shell sound
//   explo_trig    rising edge starts an explosion
//   explo_loud    explosion peak select, sampled on the trigger edge
//   audio_out     signed mixed sample
//   busy          at least one envelope nonzero
module shell_explo_sound
    import bz_sound_pkg::*;
#(
    parameter int SHELL_DECAY_DIV = 48,
    parameter int EXPLO_DECAY_DIV = 192,
    parameter int DECAY_SHIFT     = 4,
    parameter int LPF_SHIFT       = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sample_en,
    input  logic   sound_enable,
    input  logic   shell_noise,
    input  logic   explo_noise,
    input  logic   shell_trig,
    input  logic   explo_trig,
    input  logic   explo_loud,
    output audio_t audio_out,
    output logic   busy
);

    logic               prev_shell;
    logic               prev_explo;
    logic               shell_rise;
    logic               explo_rise;
    env_t               env_shell;
    env_t               env_explo;
    env_t               explo_peak;
    logic signed [8:0]  x_shell;
    logic signed [8:0]  x_explo;
    logic signed [11:0] y;
    logic signed [12:0] diff;
    logic signed [12:0] step;
    logic signed [15:0] mix;

    assign shell_rise = shell_trig & ~prev_shell;
    assign explo_rise = explo_trig & ~prev_explo;
    assign explo_peak = explo_loud ? EXPLO_PEAK_LOUD : EXPLO_PEAK_SOFT;

    env_decay #(
        .DIV         (SHELL_DECAY_DIV),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_shell (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .enable    (sound_enable),
        .start     (shell_rise),
        .peak      (SHELL_PEAK),
        .env       (env_shell)
    );

    env_decay #(
        .DIV         (EXPLO_DECAY_DIV),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_explo (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .enable    (sound_enable),
        .start     (explo_rise),
        .peak      (explo_peak),
        .env       (env_explo)
    );

    always_comb begin
        x_shell = shell_noise ? $signed({1'b0, env_shell}) : -$signed({1'b0, env_shell});
        x_explo = explo_noise ? $signed({1'b0, env_explo}) : -$signed({1'b0, env_explo});
        diff    = {{4{x_explo[8]}}, x_explo} - {y[11], y};
        step    = diff >>> LPF_SHIFT;
        // Mix uses the filter value from before this sample's update.
        mix     = {{7{x_shell[8]}}, x_shell} + {{4{y[11]}}, y};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_shell <= 1'b0;
            prev_explo <= 1'b0;
            y          <= '0;
            audio_out  <= '0;
        end else begin
            prev_shell <= shell_trig;
            prev_explo <= explo_trig;
            if (!sound_enable) begin
                y         <= '0;
                audio_out <= '0;
            end else if (sample_en) begin
                y         <= y + 12'(step);
                audio_out <= mix <<< 6;
            end
        end
    end

    assign busy = (env_shell != '0) || (env_explo != '0);

endmodule

// File: tb/tb_shell_explo_sound.sv
// tb/tb_shell_explo_sound.sv - self-checking bench for shell_explo_sound
module tb_shell_explo_sound;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        sound_enable = 1'b1;
    logic        shell_noise = 1'b1;
    logic        explo_noise = 1'b1;
    logic        shell_trig = 1'b0;
    logic        explo_trig = 1'b0;
    logic        explo_loud = 1'b0;
    logic [15:0] audio_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference state: plain integers following the audio rules directly.
    int m_env_s = 0, m_env_e = 0, m_pre_s = 0, m_pre_e = 0;
    int m_y = 0, m_audio = 0;
    bit m_prev_s = 0, m_prev_e = 0;

    always #5 clk = ~clk;

    shell_explo_sound dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .sound_enable (sound_enable),
        .shell_noise  (shell_noise),
        .explo_noise  (explo_noise),
        .shell_trig   (shell_trig),
        .explo_trig   (explo_trig),
        .explo_loud   (explo_loud),
        .audio_out    (audio_out),
        .busy         (busy)
    );

    function automatic int floor_div8(int d);
        if (d >= 0) return d / 8;
        return -((-d + 7) / 8);
    endfunction

    function automatic int decay(int e);
        int d;
        d = e / 16;
        if (d < 1) d = 1;
        return e - d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_env_s = 0; m_env_e = 0; m_pre_s = 0; m_pre_e = 0;
            m_y = 0; m_audio = 0; m_prev_s = 0; m_prev_e = 0;
        end else begin
            bit rs, re;
            int xs, xe;
            rs = shell_trig && !m_prev_s;
            re = explo_trig && !m_prev_e;
            m_prev_s = shell_trig;
            m_prev_e = explo_trig;
            if (!sound_enable) begin
                m_env_s = 0; m_env_e = 0; m_pre_s = 0; m_pre_e = 0;
                m_y = 0; m_audio = 0;
            end else begin
                if (sample_en) begin
                    xs = shell_noise ? m_env_s : -m_env_s;
                    xe = explo_noise ? m_env_e : -m_env_e;
                    m_audio = (xs + m_y) * 64;
                    m_y = m_y + floor_div8(xe - m_y);
                end
                if (rs) begin
                    m_env_s = 192; m_pre_s = 0;
                end else if (sample_en && m_env_s != 0) begin
                    m_pre_s++;
                    if (m_pre_s == 48) begin m_pre_s = 0; m_env_s = decay(m_env_s); end
                end
                if (re) begin
                    m_env_e = explo_loud ? 255 : 128; m_pre_e = 0;
                end else if (sample_en && m_env_e != 0) begin
                    m_pre_e++;
                    if (m_pre_e == 192) begin m_pre_e = 0; m_env_e = decay(m_env_e); end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the reference on every falling edge.
    always @(negedge clk) begin
        check("audio_model", int'($signed(audio_out)), m_audio);
        check("busy_model", int'(busy), int'(m_env_s != 0 || m_env_e != 0));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        sample_en = 1'b1;
        tick(1);
        sample_en = 1'b0;
        tick(1);
    endtask

    int guard;

    initial begin
        tick(2);
        check("reset_audio", int'($signed(audio_out)), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);

        // Shell start and first decay step
        shell_noise = 1'b1;
        shell_trig  = 1'b1;
        tick(1);
        shell_trig  = 1'b0;
        check("shell_busy_1clk", int'(busy), 1);
        sample();
        check("shell_first_sample", int'($signed(audio_out)), 12288);
        repeat (47) sample();
        check("model_env_180", m_env_s, 180);
        sample();
        check("shell_after_48", int'($signed(audio_out)), 11520);

        // Retrigger lands on the same sample as the 96th (wrapping) strobe
        repeat (46) sample();
        sample_en  = 1'b1;
        shell_trig = 1'b1;
        tick(1);
        sample_en  = 1'b0;
        shell_trig = 1'b0;
        tick(1);
        sample();
        check("retrig_wins", int'($signed(audio_out)), 12288);

        // Decay tail: minimum decrement and freeze at zero
        guard = 0;
        while (m_env_s != 15 && guard < 4000) begin sample(); guard++; end
        check("tail_reach_15", m_env_s, 15);
        guard = 0;
        while (m_env_s == 15 && guard < 100) begin sample(); guard++; end
        check("model_15_to_14", m_env_s, 14);
        sample();
        check("tail_audio_14", int'($signed(audio_out)), 896);
        guard = 0;
        while (busy && guard < 2000) begin sample(); guard++; end
        check("tail_busy_low", int'(busy), 0);
        sample();
        check("tail_audio_zero", int'($signed(audio_out)), 0);
        repeat (5) sample();
        check("prescaler_frozen", int'(dut.u_shell.cnt), 0);

        // Loud explosion through the filter
        explo_loud  = 1'b1;
        explo_noise = 1'b1;
        explo_trig  = 1'b1;
        tick(1);
        explo_trig  = 1'b0;
        explo_loud  = 1'b0;
        sample();
        check("loud_first", int'($signed(audio_out)), 0);
        check("model_y_31", m_y, 31);
        sample();
        check("loud_second", int'($signed(audio_out)), 1984);

        // Disable mid-sound
        sound_enable = 1'b0;
        tick(1);
        check("disable_audio", int'($signed(audio_out)), 0);
        check("disable_busy", int'(busy), 0);
        sound_enable = 1'b1;
        tick(1);

        // Soft explosion, negative noise
        explo_noise = 1'b0;
        explo_trig  = 1'b1;
        tick(1);
        explo_trig  = 1'b0;
        sample();
        check("model_y_m16", m_y, -16);
        sample();
        check("soft_second", int'($signed(audio_out)), -1024);

        // Both channels with random noise and a mid-run retrigger
        explo_loud = 1'b1;
        shell_trig = 1'b1;
        explo_trig = 1'b1;
        tick(1);
        shell_trig = 1'b0;
        explo_trig = 1'b0;
        for (int i = 0; i < 300; i++) begin
            shell_noise = 1'($urandom_range(0, 1));
            explo_noise = 1'($urandom_range(0, 1));
            if (i == 150) explo_trig = 1'b1;
            if (i == 152) explo_trig = 1'b0;
            if (i % 3 == 0) tick(1);
            sample();
        end

        // Trigger held through disable must not start a sound
        sound_enable = 1'b0;
        shell_trig   = 1'b1;
        explo_trig   = 1'b1;
        tick(3);
        sound_enable = 1'b1;
        repeat (4) sample();
        check("held_trig_busy", int'(busy), 0);
        check("held_trig_audio", int'($signed(audio_out)), 0);
        shell_trig = 1'b0;
        explo_trig = 1'b0;
        tick(1);

        // Asynchronous reset mid-sound
        shell_noise = 1'b1;
        shell_trig  = 1'b1;
        tick(1);
        shell_trig  = 1'b0;
        repeat (3) sample();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_audio", int'($signed(audio_out)), 0);
        check("async_rst_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        repeat (4) sample();
        check("post_rst_audio", int'($signed(audio_out)), 0);
        check("post_rst_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
